// File: rtl/dma_controller_pkg.sv
// ---------------------------------------------------------------------------
// dma_controller_pkg
// Shared definitions for the DMA engine: bus/word widths, block-count width,
// FSM state encoding and a helper that turns a word count into a block count.
//
// Build option: DMA_CYCLE_STEAL_EN adds the RELEASE state used to hand the bus
// back to the CPU for one cycle between blocks.
// ---------------------------------------------------------------------------
package dma_controller_pkg;

    localparam int WORD_SIZE       = 16;
    localparam int FETCH_SIZE      = 64;
    localparam int WORDS_PER_BLOCK = FETCH_SIZE / WORD_SIZE;
    localparam int BLK_SHIFT       = $clog2(WORDS_PER_BLOCK);
    // 14-bit block counter: a length of 0xFFFD..0xFFFF rounds up to 2^14
    // blocks, which wraps to 0. The last-block test compares k+1 against
    // the block count in the same width, so that case still moves 2^14 blocks.
    localparam int BLOCK_CNT_W     = WORD_SIZE - BLK_SHIFT;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_REQ     = 3'd1,
        ST_FETCH   = 3'd2,
        ST_WRITE   = 3'd3,
`ifdef DMA_CYCLE_STEAL_EN
        ST_RELEASE = 3'd4,
`endif
        ST_DONE    = 3'd5
    } dma_state_e;

    // ceil(len / WORDS_PER_BLOCK) truncated to the block-counter width.
    function automatic logic [BLOCK_CNT_W-1:0] blocks_for_length(
        input logic [WORD_SIZE-1:0] len
    );
        return len[WORD_SIZE-1:BLK_SHIFT] + BLOCK_CNT_W'(|len[BLK_SHIFT-1:0]);
    endfunction

endpackage

// File: rtl/dma_controller_addr_counter.sv
// ---------------------------------------------------------------------------
// dma_addr_counter
// Holds the transfer base address, the block count and the number of blocks
// already written (k). Produces the current block address base + 4*k
// (wrapping modulo 2^WORD_SIZE) and a flag that the current block is the last.
//
// Ports:
//   clk, srst   - clock, synchronous active-high reset
//   load        - latch base_in / blocks_in and clear k
//   base_in     - destination word address of the transfer
//   blocks_in   - number of blocks in the transfer
//   advance     - one block written, k <= k + 1
//   addr        - base + WORDS_PER_BLOCK * k
//   last        - k is the final block of the transfer
// ---------------------------------------------------------------------------
module dma_addr_counter
    import dma_controller_pkg::*;
(
    input  logic                   clk,
    input  logic                   srst,
    input  logic                   load,
    input  logic [WORD_SIZE-1:0]   base_in,
    input  logic [BLOCK_CNT_W-1:0] blocks_in,
    input  logic                   advance,
    output logic [WORD_SIZE-1:0]   addr,
    output logic                   last
);

    logic [WORD_SIZE-1:0]   base_reg;
    logic [BLOCK_CNT_W-1:0] blocks_reg;
    logic [BLOCK_CNT_W-1:0] k_reg;
    logic [BLOCK_CNT_W-1:0] k_next;

    assign k_next = k_reg + BLOCK_CNT_W'(1);

    always_ff @(posedge clk) begin
        if (srst) begin
            base_reg   <= '0;
            blocks_reg <= '0;
            k_reg      <= '0;
        end else if (load) begin
            base_reg   <= base_in;
            blocks_reg <= blocks_in;
            k_reg      <= '0;
        end else if (advance) begin
            k_reg      <= k_next;
        end
    end

    // k*4 never exceeds the word width, so the sum simply wraps at 2^16.
    assign addr = base_reg + {k_reg, {BLK_SHIFT{1'b0}}};
    assign last = (k_next == blocks_reg);

endmodule

// File: rtl/dma_controller.sv
// ---------------------------------------------------------------------------
// dma_controller
// Bus-master DMA engine. Accepts a (destination address, word count) command
// from the CPU, requests the shared memory bus (BR/BG), pulls 64-bit blocks
// from a device, writes each block to memory and pulses dma_end when done.
//
// Ports:
//   Clk, Reset            - clock, synchronous active-high reset
//   cmd_valid/cmd_ready   - command handshake (ready only while idle)
//   cmd_addr, cmd_length  - destination word address, length in words
//   BR / BG               - bus request out / bus grant in
//   dev_valid/dev_ready   - device block handshake, dev_data = block
//   d_writeM, d_address,
//   d_data                - memory write request, block address, block data
//   mem_ack               - memory write complete
//   dma_end               - one-cycle end-of-transfer pulse
//   busy                  - engine not idle
//
// Build option: DMA_CYCLE_STEAL_EN - drop BR for one cycle (RELEASE) after
// every block that is not the last; without it BR is held from REQ to DONE.
// ---------------------------------------------------------------------------
module dma_controller
    import dma_controller_pkg::*;
(
    input  logic                  Clk,
    input  logic                  Reset,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [WORD_SIZE-1:0]  cmd_addr,
    input  logic [WORD_SIZE-1:0]  cmd_length,
    output logic                  BR,
    input  logic                  BG,
    input  logic                  dev_valid,
    output logic                  dev_ready,
    input  logic [FETCH_SIZE-1:0] dev_data,
    output logic                  d_writeM,
    output logic [WORD_SIZE-1:0]  d_address,
    output logic [FETCH_SIZE-1:0] d_data,
    input  logic                  mem_ack,
    output logic                  dma_end,
    output logic                  busy
);

    dma_state_e state_reg;
    dma_state_e state_next;

    logic                  accept;
    logic                  capture;
    logic                  write_done;
    logic                  last_block;
    logic [WORD_SIZE-1:0]  block_addr;
    logic [WORD_SIZE-1:0]  d_address_reg;
    logic [FETCH_SIZE-1:0] d_data_reg;

    assign accept     = cmd_valid && (state_reg == ST_IDLE);
    assign capture    = dev_valid && (state_reg == ST_FETCH);
    assign write_done = mem_ack   && (state_reg == ST_WRITE);

    dma_addr_counter u_addr_counter (
        .clk       (Clk),
        .srst      (Reset),
        .load      (accept),
        .base_in   (cmd_addr),
        .blocks_in (blocks_for_length(cmd_length)),
        .advance   (write_done),
        .addr      (block_addr),
        .last      (last_block)
    );

    // State register
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: begin
                if (cmd_valid) begin
                    state_next = (cmd_length == '0) ? ST_DONE : ST_REQ;
                end
            end
            ST_REQ: begin
                if (BG) begin
                    state_next = ST_FETCH;
                end
            end
            ST_FETCH: begin
                // A block offered in the same cycle the grant drops is still
                // taken: the handshake has already completed on the device side.
                if (dev_valid) begin
                    state_next = ST_WRITE;
                end else if (!BG) begin
                    state_next = ST_REQ;
                end
            end
            ST_WRITE: begin
                // The write in flight always finishes; BG only matters afterwards.
                if (mem_ack) begin
                    if (last_block) begin
                        state_next = ST_DONE;
                    end else begin
`ifdef DMA_CYCLE_STEAL_EN
                        state_next = ST_RELEASE;
`else
                        state_next = BG ? ST_FETCH : ST_REQ;
`endif
                    end
                end
            end
`ifdef DMA_CYCLE_STEAL_EN
            ST_RELEASE: begin
                state_next = ST_REQ;
            end
`endif
            ST_DONE: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Outputs decoded from state
    always_comb begin
        cmd_ready = (state_reg == ST_IDLE);
        busy      = (state_reg != ST_IDLE);
        BR        = (state_reg == ST_REQ) || (state_reg == ST_FETCH) ||
                    (state_reg == ST_WRITE);
        dev_ready = (state_reg == ST_FETCH);
        d_writeM  = (state_reg == ST_WRITE);
        dma_end   = (state_reg == ST_DONE);
    end

    // Write address/data are captured with the device block and stay stable
    // for the whole WRITE state.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            d_address_reg <= '0;
            d_data_reg    <= '0;
        end else if (capture) begin
            d_address_reg <= block_addr;
            d_data_reg    <= dev_data;
        end
    end

    assign d_address = d_address_reg;
    assign d_data    = d_data_reg;

endmodule

// File: tb/tb_dma_controller.sv
// ---------------------------------------------------------------------------
// tb_dma_controller
// Directed bench for dma_controller. A negedge process plays the CPU bus
// arbiter, the device and the memory, and checks every cycle against a
// transfer-level model: a queue of the (address, data) writes each accepted
// command must produce, the expected dma_end cycle and the BR release pattern.
// The main sequence adds hand-computed address/latency checks per scenario.
// ---------------------------------------------------------------------------
module tb_dma_controller;

    logic        Clk        = 1'b0;
    logic        Reset      = 1'b1;
    logic        cmd_valid  = 1'b0;
    logic [15:0] cmd_addr   = '0;
    logic [15:0] cmd_length = '0;
    logic        BG         = 1'b0;
    logic        dev_valid  = 1'b0;
    logic [63:0] dev_data   = '0;
    logic        mem_ack    = 1'b0;
    logic        cmd_ready, BR, dev_ready, d_writeM, dma_end, busy;
    logic [15:0] d_address;
    logic [63:0] d_data;

    dma_controller dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_addr   (cmd_addr),
        .cmd_length (cmd_length),
        .BR         (BR),
        .BG         (BG),
        .dev_valid  (dev_valid),
        .dev_ready  (dev_ready),
        .dev_data   (dev_data),
        .d_writeM   (d_writeM),
        .d_address  (d_address),
        .d_data     (d_data),
        .mem_ack    (mem_ack),
        .dma_end    (dma_end),
        .busy       (busy)
    );

    initial forever #5 Clk = ~Clk;

    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input logic [79:0] act, input logic [79:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, req);
        end
    endtask

    function automatic logic [63:0] pattern(input int n);
        logic [15:0] v;
        v = n[15:0];
        return {v ^ 16'hA5A5, v + 16'h1000, ~v, v * 16'd3};
    endfunction

    // ---------------- model / environment state ----------------
    bit          grant_en = 1'b1;
    logic        p_reset = 1'b1, p_accept = 1'b0, p_bg = 1'b0;
    logic        p_hs = 1'b0, p_ack = 1'b0, p_wr = 1'b0;
    logic [15:0] p_addr = '0, p_len = '0;
    logic [79:0] exp_q[$];
    logic [79:0] cur = '0;
    bit          active = 1'b0;
    bit          end_exp, rise;
    int          low_run = 0, gaps = 0, exp_gaps = 0, nblk = 0;
    int          hs = 0, ack_cnt = 0, cyc = 0;
    int          writes_seen = 0, ends_seen = 0, br_cycles = 0, dev_ready_cycles = 0;
    int          accept_cyc = 0, end_cyc = 0;
    logic [15:0] addr_log[$];

    // ---------------- per-cycle model, compare and environment ----------------
    initial begin : env
        forever begin
            @(negedge Clk);
            cyc++;
            if (p_reset) begin
                chk("rst_cmd_ready", cmd_ready, 1);
                chk("rst_BR", BR, 0);
                chk("rst_dev_ready", dev_ready, 0);
                chk("rst_d_writeM", d_writeM, 0);
                chk("rst_d_address", d_address, 0);
                chk("rst_d_data", d_data, 0);
                chk("rst_dma_end", dma_end, 0);
                chk("rst_busy", busy, 0);
                exp_q.delete();
                active  = 1'b0;
                low_run = 0;
            end else begin
                if (p_accept) begin
                    accept_cyc = cyc;
                    nblk = (int'(p_len) + 3) / 4;
                    for (int i = 0; i < nblk; i++) begin
                        exp_q.push_back({p_addr + 16'(4 * i), pattern(hs + i)});
                    end
                    if (nblk > 0) begin
                        active  = 1'b1;
                        gaps    = 0;
                        low_run = 0;
`ifdef DMA_CYCLE_STEAL_EN
                        exp_gaps = nblk - 1;
`else
                        exp_gaps = 0;
`endif
                        chk("br_after_accept", BR, 1);
                    end
                end
                end_exp = (p_accept && p_len == 16'd0) ||
                          (active && p_wr && p_ack && exp_q.size() == 0);
                chk("dma_end", dma_end, end_exp);
                if (dma_end) begin
                    ends_seen++;
                    end_cyc = cyc;
                end
                if (end_exp && active) begin
                    chk("br_low_at_end", BR, 0);
                    chk("br_release_count", gaps, exp_gaps);
                    active = 1'b0;
                end else if (active) begin
                    if (!BR) begin
                        low_run++;
                    end else begin
                        if (low_run > 0) begin
                            chk("br_release_len", low_run, 1);
                            gaps++;
                        end
                        low_run = 0;
                    end
                end else begin
                    chk("br_idle", BR, 0);
                end

                rise = d_writeM && !p_wr;
                chk("capture_to_write", rise, p_hs);
                if (p_wr && p_ack) chk("write_ends_after_ack", d_writeM, 0);
                if (rise) begin
                    writes_seen++;
                    addr_log.push_back(d_address);
                    chk("write_expected", exp_q.size() != 0, 1);
                    if (exp_q.size() != 0) begin
                        cur = exp_q.pop_front();
                        chk("write_addr", d_address, cur[79:64]);
                        chk("write_data", d_data, cur[63:0]);
                    end
                end else if (d_writeM) begin
                    chk("addr_hold", d_address, cur[79:64]);
                    chk("data_hold", d_data, cur[63:0]);
                end

                if (dev_ready) begin
                    dev_ready_cycles++;
                    chk("dev_ready_needs_grant", p_bg, 1);
                end
                if (BR) br_cycles++;
                chk("busy_vs_ready", busy, !cmd_ready);
            end

            // drive inputs for the next rising edge
            p_reset  = Reset;
            p_accept = cmd_valid && cmd_ready && !Reset;
            p_addr   = cmd_addr;
            p_len    = cmd_length;
            BG       = BR && grant_en;
            p_bg     = BG;
            dev_valid = 1'b1;
            dev_data  = pattern(hs);
            p_hs      = dev_ready && !Reset;
            if (p_hs) hs++;
            if (d_writeM && !Reset) begin
                ack_cnt++;
                if (ack_cnt == 4) begin
                    mem_ack = 1'b1;
                    ack_cnt = 0;
                end else begin
                    mem_ack = 1'b0;
                end
            end else begin
                ack_cnt = 0;
                mem_ack = 1'b0;
            end
            p_ack = mem_ack;
            p_wr  = d_writeM;
        end
    end

    // ---------------- main sequence ----------------
    task automatic clear_logs();
        writes_seen = 0;
        ends_seen   = 0;
        addr_log.delete();
    endtask

    task automatic send(input logic [15:0] a, input logic [15:0] len);
        int k;
        k = 0;
        while (!cmd_ready && k < 500) begin
            @(posedge Clk); #1;
            k++;
        end
        chk("cmd_ready_timeout", cmd_ready, 1);
        cmd_valid  = 1'b1;
        cmd_addr   = a;
        cmd_length = len;
        @(posedge Clk); #1;
        cmd_valid  = 1'b0;
    endtask

    task automatic wait_end();
        int k;
        k = 0;
        while (ends_seen == 0 && k < 2000) begin
            @(posedge Clk); #1;
            k++;
        end
        repeat (3) @(posedge Clk);
        #1;
        chk("dma_end_once", ends_seen, 1);
    endtask

    task automatic wait_writes(input int n);
        int k;
        k = 0;
        while (writes_seen < n && k < 500) begin
            @(posedge Clk); #1;
            k++;
        end
        chk("write_count_reached", writes_seen >= n, 1);
    endtask

    int br0, dr0;

    initial begin : main
        repeat (3) @(posedge Clk);
        #1 Reset = 1'b0;
        @(posedge Clk); #1;

        // basic 3-block transfer
        clear_logs();
        send(16'h01F0, 16'd12);
        wait_end();
        chk("basic_writes", addr_log.size(), 3);
        if (addr_log.size() == 3) begin
            chk("basic_addr0", addr_log[0], 16'h01F0);
            chk("basic_addr1", addr_log[1], 16'h01F4);
            chk("basic_addr2", addr_log[2], 16'h01F8);
        end

        // length 5 rounds up to two blocks
        clear_logs();
        send(16'h0100, 16'd5);
        wait_end();
        chk("len5_writes", writes_seen, 2);

        // zero length: no bus request, dma_end in the cycle after accept
        clear_logs();
        br0 = br_cycles;
        send(16'h0200, 16'd0);
        wait_end();
        chk("len0_writes", writes_seen, 0);
        chk("len0_no_br", br_cycles - br0, 0);
        chk("len0_end_latency", end_cyc - accept_cyc, 0);

        // grant lost during the second write
        clear_logs();
        send(16'h0300, 16'd12);
        wait_writes(2);
        grant_en = 1'b0;
        dr0 = dev_ready_cycles;
        repeat (12) @(posedge Clk);
        #1;
        chk("no_fetch_without_grant", dev_ready_cycles - dr0, 0);
        chk("writes_during_grant_loss", writes_seen, 2);
        chk("br_held_during_grant_loss", BR, 1);
        grant_en = 1'b1;
        wait_end();
        chk("grant_loss_writes", writes_seen, 3);

        // address wrap
        clear_logs();
        send(16'hFFF8, 16'd12);
        wait_end();
        chk("wrap_writes", addr_log.size(), 3);
        if (addr_log.size() == 3) begin
            chk("wrap_addr0", addr_log[0], 16'hFFF8);
            chk("wrap_addr1", addr_log[1], 16'hFFFC);
            chk("wrap_addr2", addr_log[2], 16'h0000);
        end

        // reset during the second write, then a fresh transfer from k=0
        clear_logs();
        send(16'h0400, 16'd12);
        wait_writes(2);
        Reset = 1'b1;
        @(posedge Clk); #1;
        Reset = 1'b0;
        chk("mid_reset_BR", BR, 0);
        chk("mid_reset_writeM", d_writeM, 0);
        chk("mid_reset_cmd_ready", cmd_ready, 1);
        clear_logs();
        send(16'h0500, 16'd8);
        wait_end();
        chk("after_reset_writes", addr_log.size(), 2);
        if (addr_log.size() == 2) begin
            chk("after_reset_addr0", addr_log[0], 16'h0500);
            chk("after_reset_addr1", addr_log[1], 16'h0504);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
